// File: rtl/cam_pkg.sv
// Shared defaults and bank state encoding for the camera line ping-pong buffer.
package cam_pkg;

  localparam int PIX_W_DEF    = 4;
  localparam int LINE_LEN_DEF = 120;
  localparam int ADDR_W_DEF   = 7;
  localparam int CNT_W_DEF    = 8;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    HELD    = 2'd2
  } bank_st_t;

endpackage

// File: rtl/cam_bank_ram.sv
// Single-clock simple dual-port line RAM: synchronous write, registered read.
module cam_bank_ram #(
  parameter int    PIX_W    = 4,
  parameter int    ADDR_W   = 7,
  parameter string MEM_FILE = "none"
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [0:(2**ADDR_W)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cam_line_pingpong.sv
// Ping-pong line buffer: camera fills one bank while the reader drains the other.
module cam_line_pingpong
  import cam_pkg::*;
#(
  parameter int    PIX_W    = PIX_W_DEF,
  parameter int    LINE_LEN = LINE_LEN_DEF,
  parameter int    ADDR_W   = ADDR_W_DEF,
  parameter int    CNT_W    = CNT_W_DEF,
  parameter string MEM_FILE = "none"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              line_end,
  output logic              line_valid,
  output logic [ADDR_W:0]   line_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              trunc_err
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(LINE_LEN);

  bank_st_t          bank_st [0:1];
  logic              wbank;
  logic              obank;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   ptr_next;
  logic              wr_fire;
  logic              release_ok;
  logic              other_free;
  logic              rd_ok;
  logic              rd_ok_q;
  logic              rd_sel_q;
  logic [PIX_W-1:0]  q0;
  logic [PIX_W-1:0]  q1;

  assign obank = ~wbank;

  // Write acceptance, pointer advance and swap eligibility for this cycle.
  always_comb begin
    wr_fire    = pix_valid && (wr_ptr < LEN_MAX);
    ptr_next   = wr_fire ? wr_ptr + 1'b1 : wr_ptr;
    release_ok = rd_release && line_valid;
    // A release in the same cycle frees the other bank before the swap decision.
    other_free = (bank_st[obank] != HELD) || release_ok;
    rd_ok      = rd_en && line_valid && ({1'b0, rd_addr} < line_len);
  end

  // Bank state machine, write pointer, line length and error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank      <= 1'b0;
      wr_ptr     <= '0;
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
      line_valid <= 1'b0;
      line_len   <= '0;
      drop_cnt   <= '0;
      trunc_err  <= 1'b0;
    end else begin
      wr_ptr          <= ptr_next;
      bank_st[wbank]  <= FILLING;
      if (pix_valid && !wr_fire) trunc_err <= 1'b1;
      if (release_ok) begin
        bank_st[obank] <= FREE;
        line_valid     <= 1'b0;
      end
      if (frame_start) begin
        wr_ptr <= '0;
      end else if (line_end && (ptr_next != '0)) begin
        wr_ptr <= '0;
        if (other_free) begin
          bank_st[wbank] <= HELD;
          bank_st[obank] <= FILLING;
          wbank          <= obank;
          line_len       <= ptr_next;
          line_valid     <= 1'b1;
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  // Read-side pipeline: remember which bank answers and whether the hit is in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_ok_q  <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_ok_q  <= rd_ok;
      rd_sel_q <= obank;
    end
  end

  assign rd_data = rd_ok_q ? (rd_sel_q ? q1 : q0) : '0;

  cam_bank_ram #(
    .PIX_W    (PIX_W),
    .ADDR_W   (ADDR_W),
    .MEM_FILE (MEM_FILE)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_fire && (wbank == 1'b0)),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (pix_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (q0)
  );

  cam_bank_ram #(
    .PIX_W    (PIX_W),
    .ADDR_W   (ADDR_W),
    .MEM_FILE (MEM_FILE)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_fire && (wbank == 1'b1)),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (pix_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (q1)
  );

endmodule

// File: tb/tb_cam_line_pingpong.sv
// Directed self-checking bench for cam_line_pingpong with default parameters.
module tb_cam_line_pingpong;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [3:0] pix_data = '0;
  logic       line_end = 1'b0;
  logic       line_valid;
  logic [7:0] line_len;
  logic       rd_en = 1'b0;
  logic [6:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       rd_release = 1'b0;
  logic [7:0] drop_cnt;
  logic       trunc_err;

  int total = 0;
  int bad   = 0;

  cam_line_pingpong #(
    .PIX_W    (4),
    .LINE_LEN (120),
    .ADDR_W   (7),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .line_end    (line_end),
    .line_valid  (line_valid),
    .line_len    (line_len),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_release  (rd_release),
    .drop_cnt    (drop_cnt),
    .trunc_err   (trunc_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pix(input logic [3:0] v, input logic le);
    pix_valid = 1'b1;
    pix_data  = v;
    line_end  = le;
    tick();
    pix_valid = 1'b0;
    line_end  = 1'b0;
  endtask

  task automatic end_line;
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
  endtask

  task automatic release_line;
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL rst_line_valid got=%0b want=0", line_valid); end
    total++; if (line_len !== 8'd0) begin bad++; $display("FAIL rst_line_len got=%0d want=0", line_len); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0b want=0", rd_valid); end
    total++; if (rd_data !== 4'd0) begin bad++; $display("FAIL rst_rd_data got=%0h want=0", rd_data); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop_cnt got=%0d want=0", drop_cnt); end
    total++; if (trunc_err !== 1'b0) begin bad++; $display("FAIL rst_trunc_err got=%0b want=0", trunc_err); end
  endtask

  task automatic test_full_line;
    logic [6:0] a;
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      a = 7'(i);
      pix(a[3:0], 1'b0);
    end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL full_pre_valid got=%0b want=0", line_valid); end
    end_line();
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL full_line_valid got=%0b want=1", line_valid); end
    total++; if (line_len !== 8'd120) begin bad++; $display("FAIL full_line_len got=%0d want=120", line_len); end
    // back-to-back reads, one per cycle, addresses 0..127
    for (int i = 0; i < 128; i++) begin
      a = 7'(i);
      exp = (i < 120) ? a[3:0] : 4'd0;
      rd_en = 1'b1;
      rd_addr = a;
      tick();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        bad++;
        $display("FAIL full_read addr=%0d got valid=%0b data=%0h want valid=1 data=%0h", i, rd_valid, rd_data, exp);
      end
    end
    rd_en = 1'b0;
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL full_rd_idle got=%0b want=0", rd_valid); end
    release_line();
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL full_release got=%0b want=0", line_valid); end
    rd_en = 1'b1;
    rd_addr = 7'd3;
    tick();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 4'd0) begin bad++; $display("FAIL full_read_empty got valid=%0b data=%0h want 1/0", rd_valid, rd_data); end
  endtask

  task automatic test_overrun;
    logic [3:0] expc [0:3];
    do_reset();
    for (int i = 0; i < 4; i++) pix(4'hA, 1'b0);
    end_line();
    for (int i = 0; i < 6; i++) pix(4'h5, 1'b0);
    end_line();
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL ovr_drop got=%0d want=1", drop_cnt); end
    total++; if (line_len !== 8'd4) begin bad++; $display("FAIL ovr_len got=%0d want=4", line_len); end
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%0b want=1", line_valid); end
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      rd_addr = 7'(i);
      tick();
      total++;
      if (rd_data !== ((i < 4) ? 4'hA : 4'h0)) begin
        bad++;
        $display("FAIL ovr_read_a addr=%0d got=%0h want=%0h", i, rd_data, (i < 4) ? 4'hA : 4'h0);
      end
    end
    rd_en = 1'b0;
    release_line();
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL ovr_release got=%0b want=0", line_valid); end
    pix(4'h3, 1'b0);
    pix(4'h2, 1'b0);
    pix(4'h1, 1'b1);
    total++; if (line_valid !== 1'b1 || line_len !== 8'd3) begin bad++; $display("FAIL ovr_c_line got valid=%0b len=%0d want 1/3", line_valid, line_len); end
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL ovr_c_drop got=%0d want=1", drop_cnt); end
    expc[0] = 4'h3; expc[1] = 4'h2; expc[2] = 4'h1; expc[3] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      rd_addr = 7'(i);
      tick();
      total++;
      if (rd_data !== expc[i]) begin bad++; $display("FAIL ovr_read_c addr=%0d got=%0h want=%0h", i, rd_data, expc[i]); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_trunc;
    logic [6:0] a;
    do_reset();
    for (int i = 0; i < 125; i++) begin
      a = 7'(i);
      pix((i >= 120) ? 4'hF : (a[3:0] ^ 4'h5), 1'b0);
    end
    total++; if (trunc_err !== 1'b1) begin bad++; $display("FAIL trunc_flag got=%0b want=1", trunc_err); end
    end_line();
    total++; if (line_len !== 8'd120) begin bad++; $display("FAIL trunc_len got=%0d want=120", line_len); end
    rd_en = 1'b1;
    rd_addr = 7'd119;
    tick();
    total++; if (rd_data !== 4'h2) begin bad++; $display("FAIL trunc_last got=%0h want=2", rd_data); end
    rd_addr = 7'd120;
    tick();
    rd_en = 1'b0;
    total++; if (rd_data !== 4'h0) begin bad++; $display("FAIL trunc_past got=%0h want=0", rd_data); end
    release_line();
    total++; if (trunc_err !== 1'b1) begin bad++; $display("FAIL trunc_sticky got=%0b want=1", trunc_err); end
  endtask

  task automatic test_release_swap;
    do_reset();
    for (int i = 0; i < 10; i++) pix(4'h7, 1'b0);
    end_line();
    for (int i = 0; i < 50; i++) pix(4'h9, 1'b0);
    rd_release = 1'b1;
    line_end = 1'b1;
    tick();
    rd_release = 1'b0;
    line_end = 1'b0;
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL swap_drop got=%0d want=0", drop_cnt); end
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL swap_valid got=%0b want=1", line_valid); end
    total++; if (line_len !== 8'd50) begin bad++; $display("FAIL swap_len got=%0d want=50", line_len); end
    rd_en = 1'b1;
    rd_addr = 7'd49;
    tick();
    rd_en = 1'b0;
    total++; if (rd_data !== 4'h9) begin bad++; $display("FAIL swap_read got=%0h want=9", rd_data); end
  endtask

  task automatic test_frame_start;
    do_reset();
    for (int i = 0; i < 30; i++) pix(4'h4, 1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 10; i++) pix(4'h6, 1'b0);
    end_line();
    total++; if (line_len !== 8'd10 || line_valid !== 1'b1) begin bad++; $display("FAIL fs_len got len=%0d valid=%0b want 10/1", line_len, line_valid); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL fs_drop got=%0d want=0", drop_cnt); end
    for (int i = 0; i < 5; i++) pix(4'h8, 1'b0);
    frame_start = 1'b1;
    line_end = 1'b1;
    tick();
    frame_start = 1'b0;
    line_end = 1'b0;
    total++; if (line_len !== 8'd10 || drop_cnt !== 8'd0) begin bad++; $display("FAIL fs_override got len=%0d drop=%0d want 10/0", line_len, drop_cnt); end
    rd_en = 1'b1;
    rd_addr = 7'd9;
    tick();
    rd_en = 1'b0;
    total++; if (rd_data !== 4'h6) begin bad++; $display("FAIL fs_read got=%0h want=6", rd_data); end
  endtask

  task automatic test_rst_mid;
    do_reset();
    for (int i = 0; i < 3; i++) pix(4'h1, 1'b0);
    end_line();
    for (int i = 0; i < 2; i++) pix(4'h2, 1'b0);
    end_line();
    for (int i = 0; i < 130; i++) pix(4'h3, 1'b0);
    total++; if (drop_cnt !== 8'd1 || trunc_err !== 1'b1) begin bad++; $display("FAIL rm_pre got drop=%0d trunc=%0b want 1/1", drop_cnt, trunc_err); end
    rst = 1'b1;
    rd_en = 1'b1;
    rd_addr = 7'd0;
    pix_valid = 1'b1;
    tick();
    rst = 1'b0;
    rd_en = 1'b0;
    pix_valid = 1'b0;
    total++; if (line_valid !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got lv=%0b rv=%0b want 0/0", line_valid, rd_valid); end
    total++; if (drop_cnt !== 8'd0 || trunc_err !== 1'b0) begin bad++; $display("FAIL rm_err got drop=%0d trunc=%0b want 0/0", drop_cnt, trunc_err); end
    end_line();
    total++; if (line_valid !== 1'b0 || line_len !== 8'd0) begin bad++; $display("FAIL rm_empty_end got lv=%0b len=%0d want 0/0", line_valid, line_len); end
  endtask

  initial begin
    tick();
    test_reset();
    test_full_line();
    test_overrun();
    test_trunc();
    test_release_swap();
    test_frame_start();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
